sound_glu: RTL and testbench

Responder for the IIgs Sound GLU soft switches $C03C–$C03F. Sits behind the top-level IO decoder on the same single-cycle strobe interface the top uses for its other IO responders, and bridges CPU accesses to the 64 KB sound RAM (request/acknowledge port) or the DOC register file (single-cycle port). Owns SOUNDCTL, SOUNDDATA, SOUNDADRL and SOUNDADRH, address auto-increment, the one-deep stale read latch and the busy flag.

---
 rtl/sound_glu.sv | 242 ++++++++++++++++++++++++
 tb/tb_sound_glu.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sound_glu.sv
// sound_glu - IIgs Sound GLU soft-switch responder ($C03C-$C03F).
//
// Bridges CPU accesses from the IO decoder strobe interface to either the
// sound RAM (request/acknowledge) or the DOC register file (single-cycle).
// Owns SOUNDCTL, SOUNDDATA, SOUNDADRL/H, address auto-increment, the
// one-deep stale read latch and the busy flag.
//
// Build option: SOUNDGLU_BUSY_EN
//   defined   - CTL bit7 reads busy; DATA accesses while busy are dropped.
//   undefined - CTL bit7 reads 0; DATA accesses while busy are held in a
//               one-entry queue (last one wins) and launch on return to idle.
//
// Ports:
//   clk_sys, reset         clock, async active-high reset
//   strobe, rw, addr, din  single-cycle IO access (rw=1 read)
//   dout                   registered read data
//   ram_*                  sound RAM request/acknowledge port
//   doc_*                  DOC register port (rdata valid cycle after doc_re)
//   volume                 SOUNDCTL[3:0]

module sound_glu #(
    parameter int RAM_AW = 16
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic              strobe,
    input  logic              rw,
    input  logic [7:0]        addr,
    input  logic [7:0]        din,
    output logic [7:0]        dout,
    output logic              ram_req,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [7:0]        ram_wdata,
    input  logic [7:0]        ram_rdata,
    input  logic              ram_ack,
    output logic [7:0]        doc_addr,
    output logic              doc_we,
    output logic              doc_re,
    output logic [7:0]        doc_wdata,
    input  logic [7:0]        doc_rdata,
    output logic [3:0]        volume
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RAM_WAIT,
        S_DOC_WR,
        S_DOC_RD,
        S_DOC_CAP
    } state_t;

    state_t            state_q;
    logic [6:0]        ctl_q;
    logic [RAM_AW-1:0] a_q;
    logic [RAM_AW-1:0] a_d;
    logic [7:0]        latch_q;
    logic [7:0]        dout_q;
    logic              ram_req_q;
    logic              ram_we_q;
    logic [RAM_AW-1:0] ram_addr_q;
    logic [7:0]        ram_wdata_q;
    logic [7:0]        doc_addr_q;
    logic              doc_we_q;
    logic              doc_re_q;
    logic [7:0]        doc_wdata_q;

    logic              busy;
    logic              busy_rd;
    logic              data_acc;
    logic [15:0]       a16;
    logic              go;
    logic              go_rw;
    logic [RAM_AW-1:0] go_addr;
    logic [7:0]        go_data;
    logic              inc;

`ifndef SOUNDGLU_BUSY_EN
    logic              q_valid_q;
    logic              q_rw_q;
    logic [RAM_AW-1:0] q_addr_q;
    logic [7:0]        q_data_q;
    logic              q_load;
`endif

    assign busy     = (state_q != S_IDLE);
    assign data_acc = strobe && (addr == 8'h3D);
    assign a16      = 16'(a_q);

`ifdef SOUNDGLU_BUSY_EN
    assign busy_rd = busy;
`else
    assign busy_rd = 1'b0;
`endif

    // Launch selection. A launch always captures the address as it stands
    // now; the increment lands in a_q on the same edge.
    always_comb begin
        go      = 1'b0;
        go_rw   = rw;
        go_addr = a_q;
        go_data = din;
`ifdef SOUNDGLU_BUSY_EN
        if (data_acc && !busy) begin
            go = 1'b1;
        end
        inc = data_acc && !busy && ctl_q[5];
`else
        q_load = 1'b0;
        if (!busy && q_valid_q) begin
            // Queued access goes first; a strobe in this same cycle
            // takes its place in the queue.
            go      = 1'b1;
            go_rw   = q_rw_q;
            go_addr = q_addr_q;
            go_data = q_data_q;
            q_load  = data_acc;
        end else if (data_acc && !busy) begin
            go = 1'b1;
        end else if (data_acc) begin
            q_load = 1'b1;
        end
        // Queued accesses also take their increment at strobe time.
        inc = data_acc && ctl_q[5];
`endif
    end

    always_comb begin
        a_d = a_q;
        if (inc) begin
            a_d = a_q + RAM_AW'(1);
        end else if (strobe && !rw && addr == 8'h3E) begin
            a_d = RAM_AW'({a16[15:8], din});
        end else if (strobe && !rw && addr == 8'h3F) begin
            a_d = RAM_AW'({din, a16[7:0]});
        end
    end

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            ctl_q       <= '0;
            a_q         <= '0;
            latch_q     <= '0;
            dout_q      <= '0;
            ram_req_q   <= 1'b0;
            ram_we_q    <= 1'b0;
            ram_addr_q  <= '0;
            ram_wdata_q <= '0;
            doc_addr_q  <= '0;
            doc_we_q    <= 1'b0;
            doc_re_q    <= 1'b0;
            doc_wdata_q <= '0;
`ifndef SOUNDGLU_BUSY_EN
            q_valid_q   <= 1'b0;
            q_rw_q      <= 1'b0;
            q_addr_q    <= '0;
            q_data_q    <= '0;
`endif
        end else begin
            doc_we_q <= 1'b0;
            doc_re_q <= 1'b0;
            a_q      <= a_d;

            if (strobe && !rw && addr == 8'h3C) begin
                ctl_q <= din[6:0];
            end

            if (strobe && rw) begin
                case (addr)
                    8'h3C:   dout_q <= {busy_rd, ctl_q};
                    8'h3D:   dout_q <= latch_q;
                    8'h3E:   dout_q <= a16[7:0];
                    8'h3F:   dout_q <= a16[15:8];
                    default: dout_q <= dout_q;
                endcase
            end

`ifndef SOUNDGLU_BUSY_EN
            if (q_load) begin
                q_valid_q <= 1'b1;
                q_rw_q    <= rw;
                q_addr_q  <= a_q;
                q_data_q  <= din;
            end else if (go) begin
                q_valid_q <= 1'b0;
            end
`endif

            case (state_q)
                S_IDLE: begin
                    if (go) begin
                        if (ctl_q[6]) begin
                            state_q     <= S_RAM_WAIT;
                            ram_req_q   <= 1'b1;
                            ram_we_q    <= !go_rw;
                            ram_addr_q  <= go_addr;
                            ram_wdata_q <= go_data;
                        end else if (go_rw) begin
                            state_q    <= S_DOC_RD;
                            doc_re_q   <= 1'b1;
                            doc_addr_q <= go_addr[7:0];
                        end else begin
                            state_q     <= S_DOC_WR;
                            doc_we_q    <= 1'b1;
                            doc_addr_q  <= go_addr[7:0];
                            doc_wdata_q <= go_data;
                        end
                    end
                end
                S_RAM_WAIT: begin
                    if (ram_ack) begin
                        ram_req_q <= 1'b0;
                        if (!ram_we_q) begin
                            latch_q <= ram_rdata;
                        end
                        state_q <= S_IDLE;
                    end
                end
                S_DOC_WR: state_q <= S_IDLE;
                S_DOC_RD: state_q <= S_DOC_CAP;
                S_DOC_CAP: begin
                    latch_q <= doc_rdata;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign dout      = dout_q;
    assign ram_req   = ram_req_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = ram_addr_q;
    assign ram_wdata = ram_wdata_q;
    assign doc_addr  = doc_addr_q;
    assign doc_we    = doc_we_q;
    assign doc_re    = doc_re_q;
    assign doc_wdata = doc_wdata_q;
    assign volume    = ctl_q[3:0];

endmodule

// File: tb/tb_sound_glu.sv
module tb_sound_glu;

    logic        clk_sys = 1'b0;
    logic        reset   = 1'b1;
    logic        strobe  = 1'b0;
    logic        rw      = 1'b0;
    logic [7:0]  addr    = 8'h00;
    logic [7:0]  din     = 8'h00;
    logic [7:0]  dout;
    logic        ram_req;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic [7:0]  ram_rdata = 8'h00;
    logic        ram_ack   = 1'b0;
    logic [7:0]  doc_addr;
    logic        doc_we;
    logic        doc_re;
    logic [7:0]  doc_wdata;
    logic [7:0]  doc_rdata = 8'h00;
    logic [3:0]  volume;

    int checks = 0;
    int errors = 0;

    sound_glu #(.RAM_AW(16)) dut (
        .clk_sys   (clk_sys),
        .reset     (reset),
        .strobe    (strobe),
        .rw        (rw),
        .addr      (addr),
        .din       (din),
        .dout      (dout),
        .ram_req   (ram_req),
        .ram_we    (ram_we),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_rdata (ram_rdata),
        .ram_ack   (ram_ack),
        .doc_addr  (doc_addr),
        .doc_we    (doc_we),
        .doc_re    (doc_re),
        .doc_wdata (doc_wdata),
        .doc_rdata (doc_rdata),
        .volume    (volume)
    );

    always #5 clk_sys = ~clk_sys;

    // Inputs change and outputs are sampled 1 ns after the rising edge.
    task automatic tick();
        @(posedge clk_sys);
        #1;
    endtask

    task automatic io(input logic r, input logic [7:0] a, input logic [7:0] d);
        strobe = 1'b1;
        rw     = r;
        addr   = a;
        din    = d;
        tick();
        strobe = 1'b0;
        rw     = 1'b0;
    endtask

    task automatic ack(input logic [7:0] d);
        ram_ack   = 1'b1;
        ram_rdata = d;
        tick();
        ram_ack = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        if (dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h exp 00", dout); end
        checks++;
        if (ram_req !== 1'b0 || doc_we !== 1'b0 || doc_re !== 1'b0) begin
            errors++; $display("FAIL reset_req got %b%b%b exp 000", ram_req, doc_we, doc_re);
        end
        checks++;
        if (volume !== 4'h0) begin errors++; $display("FAIL reset_volume got %h exp 0", volume); end
        checks++;
        tick();
        reset = 1'b0;
        tick();
        io(1'b1, 8'h3C, 8'h00);
        if (dout !== 8'h00) begin errors++; $display("FAIL reset_ctl got %h exp 00", dout); end
        checks++;
    endtask

    task automatic test_ram_write_autoinc();
        logic [7:0] exp_ctl;
`ifdef SOUNDGLU_BUSY_EN
        exp_ctl = 8'hE0;
`else
        exp_ctl = 8'h60;
`endif
        io(1'b0, 8'h3C, 8'h60);
        io(1'b0, 8'h3E, 8'hFF);
        io(1'b0, 8'h3F, 8'hFF);
        io(1'b0, 8'h3D, 8'hA5);
        if (ram_req !== 1'b1 || ram_we !== 1'b1 || ram_addr !== 16'hFFFF || ram_wdata !== 8'hA5) begin
            errors++;
            $display("FAIL ramwr_launch got req=%b we=%b addr=%h data=%h exp 1 1 ffff a5",
                     ram_req, ram_we, ram_addr, ram_wdata);
        end
        checks++;
        io(1'b1, 8'h3C, 8'h00);
        if (dout !== exp_ctl) begin errors++; $display("FAIL ramwr_ctl_busy got %h exp %h", dout, exp_ctl); end
        checks++;
        io(1'b1, 8'h3E, 8'h00);
        if (dout !== 8'h00) begin errors++; $display("FAIL ramwr_adrl_wrap got %h exp 00", dout); end
        checks++;
        io(1'b1, 8'h3F, 8'h00);
        if (dout !== 8'h00) begin errors++; $display("FAIL ramwr_adrh_wrap got %h exp 00", dout); end
        checks++;
        if (ram_req !== 1'b1 || ram_addr !== 16'hFFFF) begin
            errors++; $display("FAIL ramwr_hold got req=%b addr=%h exp 1 ffff", ram_req, ram_addr);
        end
        checks++;
        ack(8'h00);
        if (ram_req !== 1'b0) begin errors++; $display("FAIL ramwr_req_drop got %b exp 0", ram_req); end
        checks++;
        io(1'b1, 8'h3C, 8'h00);
        if (dout !== 8'h60) begin errors++; $display("FAIL ramwr_ctl_idle got %h exp 60", dout); end
        checks++;
    endtask

    task automatic test_stale_read();
        logic [7:0] rdv [3] = '{8'h11, 8'h22, 8'h33};
        logic [7:0] expv[3] = '{8'h00, 8'h11, 8'h22};
        io(1'b0, 8'h3E, 8'h00);
        io(1'b0, 8'h3F, 8'h01);
        for (int i = 0; i < 3; i++) begin
            io(1'b1, 8'h3D, 8'h00);
            if (dout !== expv[i]) begin errors++; $display("FAIL stale_dout%0d got %h exp %h", i, dout, expv[i]); end
            checks++;
            if (ram_req !== 1'b1 || ram_we !== 1'b0 || ram_addr !== (16'h0100 + 16'(i))) begin
                errors++;
                $display("FAIL stale_req%0d got req=%b we=%b addr=%h exp 1 0 %h",
                         i, ram_req, ram_we, ram_addr, 16'h0100 + 16'(i));
            end
            checks++;
            tick();
            ack(rdv[i]);
            tick();
        end
        io(1'b1, 8'h3E, 8'h00);
        if (dout !== 8'h03) begin errors++; $display("FAIL stale_adrl got %h exp 03", dout); end
        checks++;
        io(1'b1, 8'h3F, 8'h00);
        if (dout !== 8'h01) begin errors++; $display("FAIL stale_adrh got %h exp 01", dout); end
        checks++;
    endtask

    task automatic test_doc_read();
        doc_rdata = 8'h7E;
        io(1'b0, 8'h3C, 8'h00);
        io(1'b0, 8'h3E, 8'h05);
        io(1'b0, 8'h3F, 8'h00);
        io(1'b1, 8'h3D, 8'h00);
        if (doc_re !== 1'b1 || doc_addr !== 8'h05 || ram_req !== 1'b0) begin
            errors++; $display("FAIL docrd_pulse1 got re=%b addr=%h req=%b exp 1 05 0", doc_re, doc_addr, ram_req);
        end
        checks++;
        if (dout !== 8'h33) begin errors++; $display("FAIL docrd_stale got %h exp 33", dout); end
        checks++;
        tick();
        if (doc_re !== 1'b0) begin errors++; $display("FAIL docrd_pulse_width got %b exp 0", doc_re); end
        checks++;
        tick();
        io(1'b1, 8'h3D, 8'h00);
        if (dout !== 8'h7E || doc_re !== 1'b1) begin
            errors++; $display("FAIL docrd_second got dout=%h re=%b exp 7e 1", dout, doc_re);
        end
        checks++;
        tick();
        tick();
        io(1'b1, 8'h3E, 8'h00);
        if (dout !== 8'h05) begin errors++; $display("FAIL docrd_noinc got %h exp 05", dout); end
        checks++;
    endtask

    task automatic test_doc_write();
        io(1'b0, 8'h3C, 8'h20);
        io(1'b0, 8'h3E, 8'h10);
        io(1'b0, 8'h3D, 8'h5A);
        if (doc_we !== 1'b1 || doc_addr !== 8'h10 || doc_wdata !== 8'h5A) begin
            errors++; $display("FAIL docwr_pulse got we=%b addr=%h data=%h exp 1 10 5a", doc_we, doc_addr, doc_wdata);
        end
        checks++;
        io(1'b1, 8'h3E, 8'h00);
        if (doc_we !== 1'b0 || dout !== 8'h11) begin
            errors++; $display("FAIL docwr_after got we=%b adrl=%h exp 0 11", doc_we, dout);
        end
        checks++;
    endtask

    task automatic test_ctl_bit7();
        io(1'b0, 8'h3C, 8'hFF);
        io(1'b1, 8'h3C, 8'h00);
        if (dout !== 8'h7F || volume !== 4'hF) begin
            errors++; $display("FAIL ctl_bit7 got ctl=%h vol=%h exp 7f f", dout, volume);
        end
        checks++;
    endtask

    task automatic test_back_to_back();
        io(1'b0, 8'h3C, 8'h60);
        io(1'b0, 8'h3E, 8'h00);
        io(1'b0, 8'h3F, 8'h02);
        io(1'b0, 8'h3D, 8'h01);
        io(1'b0, 8'h3D, 8'h02);
        if (ram_req !== 1'b1 || ram_addr !== 16'h0200 || ram_wdata !== 8'h01) begin
            errors++; $display("FAIL b2b_first got req=%b addr=%h data=%h exp 1 0200 01", ram_req, ram_addr, ram_wdata);
        end
        checks++;
`ifdef SOUNDGLU_BUSY_EN
        io(1'b1, 8'h3D, 8'h00);
        if (dout !== 8'h7E) begin errors++; $display("FAIL busy_latch got %h exp 7e", dout); end
        checks++;
        io(1'b1, 8'h3E, 8'h00);
        if (dout !== 8'h01) begin errors++; $display("FAIL busy_inc_once got %h exp 01", dout); end
        checks++;
        ack(8'h00);
        tick();
        tick();
        if (ram_req !== 1'b0) begin errors++; $display("FAIL busy_no_second got %b exp 0", ram_req); end
        checks++;
        io(1'b1, 8'h3D, 8'h00);
        if (dout !== 8'h7E) begin errors++; $display("FAIL busy_latch_kept got %h exp 7e", dout); end
        checks++;
        tick();
        ack(8'h00);
`else
        io(1'b1, 8'h3C, 8'h00);
        if (dout !== 8'h60) begin errors++; $display("FAIL b2b_ctl_pending got %h exp 60", dout); end
        checks++;
        ack(8'h00);
        if (ram_req !== 1'b0) begin errors++; $display("FAIL b2b_gap got %b exp 0", ram_req); end
        checks++;
        tick();
        if (ram_req !== 1'b1 || ram_addr !== 16'h0201 || ram_wdata !== 8'h02 || ram_we !== 1'b1) begin
            errors++;
            $display("FAIL b2b_second got req=%b addr=%h data=%h we=%b exp 1 0201 02 1",
                     ram_req, ram_addr, ram_wdata, ram_we);
        end
        checks++;
        io(1'b1, 8'h3E, 8'h00);
        if (dout !== 8'h02) begin errors++; $display("FAIL b2b_adrl got %h exp 02", dout); end
        checks++;
        io(1'b1, 8'h3C, 8'h00);
        if (dout !== 8'h60) begin errors++; $display("FAIL b2b_ctl_bit7 got %h exp 60", dout); end
        checks++;
        ack(8'h00);
        tick();
        if (ram_req !== 1'b0) begin errors++; $display("FAIL b2b_done got %b exp 0", ram_req); end
        checks++;
`endif
    endtask

    task automatic test_reset_mid();
        io(1'b0, 8'h3C, 8'h6A);
        io(1'b0, 8'h3E, 8'h34);
        io(1'b1, 8'h3E, 8'h00);
        io(1'b0, 8'h3D, 8'h77);
        if (ram_req !== 1'b1 || dout !== 8'h34) begin
            errors++; $display("FAIL rstmid_pre got req=%b dout=%h exp 1 34", ram_req, dout);
        end
        checks++;
        #2;
        reset = 1'b1;
        #1;
        if (ram_req !== 1'b0 || dout !== 8'h00 || volume !== 4'h0) begin
            errors++; $display("FAIL rstmid_async got req=%b dout=%h vol=%h exp 0 00 0", ram_req, dout, volume);
        end
        checks++;
        tick();
        #2;
        reset = 1'b0;
        tick();
        ack(8'hCC);
        tick();
        if (ram_req !== 1'b0) begin errors++; $display("FAIL rstmid_ack_ignored got %b exp 0", ram_req); end
        checks++;
        io(1'b1, 8'h3C, 8'h00);
        if (dout !== 8'h00) begin errors++; $display("FAIL rstmid_ctl got %h exp 00", dout); end
        checks++;
        io(1'b1, 8'h3D, 8'h00);
        if (dout !== 8'h00) begin errors++; $display("FAIL rstmid_latch got %h exp 00", dout); end
        checks++;
        tick();
        tick();
    endtask

    initial begin
        test_reset();
        test_ram_write_autoinc();
        test_stale_read();
        test_doc_read();
        test_doc_write();
        test_ctl_bit7();
        test_back_to_back();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
